// File: rtl/decrypt_pkg.sv
// Shared types and constants for the LFSR stream-decryption sequencer.
// The preamble character's low six bits double as the seed/candidate mask.
package decrypt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    PRIME,
    TRAIN,
    STREAM,
    DONE
  } seq_state_t;

  localparam int N_LFSR = 6;

  localparam logic [7:0] PREAMBLE_CHAR = 8'h5F;
  localparam logic [5:0] SEED_MASK     = 6'h1F;

  localparam logic [5:0] LFSR_TAPS [N_LFSR] = '{6'h21, 6'h2D, 6'h30, 6'h33, 6'h36, 6'h39};

  // Preamble bytes carry PREAMBLE_CHAR, so un-masking a byte yields the keystream value.
  function automatic logic [5:0] seed_of(input logic [7:0] b);
    return b[5:0] ^ SEED_MASK;
  endfunction

endpackage

// File: rtl/onehot_prio_enc.sv
// Priority encoder: highest set bit of a one-hot-ish vector wins.
// An all-zero vector gives index 0 with the none flag raised.
module onehot_prio_enc
  import decrypt_pkg::*;
(
  input  logic [N_LFSR-1:0] vec,
  output logic [2:0]        idx,
  output logic              none
);

  always_comb begin
    idx = '0;
    for (int i = 0; i < N_LFSR; i++) begin
      if (vec[i]) idx = 3'(i);
    end
  end

  assign none = ~|vec;

endmodule

// File: rtl/decrypt_seq_ctrl.sv
// Sequencer for the LFSR stream-decryption datapath: seeds the LFSR bank,
// identifies the matching tap from the preamble and writes back the payload.
module decrypt_seq_ctrl
  import decrypt_pkg::*;
#(
  parameter int SRC_BASE = 64,
  parameter int DST_BASE = 0,
  parameter int MSG_LEN  = 64,
  parameter int PRE_LEN  = 7
) (
  input  logic                   clk,
  input  logic                   init_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [7:0]             mem_raddr,
  input  logic [7:0]             mem_rdata,
  output logic [7:0]             mem_waddr,
  output logic [7:0]             mem_wdata,
  output logic                   mem_wr_en,
  output logic                   lfsr_load,
  output logic                   lfsr_en,
  output logic [5:0]             lfsr_start,
  input  logic [N_LFSR-1:0][5:0] lfsr_state,
  output logic [2:0]             tap_sel
);

  localparam logic [7:0] SRC        = 8'(SRC_BASE);
  localparam logic [7:0] DST        = 8'(DST_BASE);
  localparam logic [7:0] PRE        = 8'(PRE_LEN);
  localparam logic [7:0] LAST_TRAIN = 8'(PRE_LEN - 1);
  localparam logic [7:0] LAST_BYTE  = 8'(MSG_LEN - 1);

  seq_state_t        state, state_nxt;
  logic [7:0]        rd_ptr, rd_ptr_nxt;
  logic [2:0]        tap_sel_nxt;
  logic              err_nxt;
  logic [5:0]        candidate;
  logic [N_LFSR-1:0] match;
  logic [2:0]        match_idx;
  logic              match_none;

  assign candidate  = seed_of(mem_rdata);
  assign lfsr_start = candidate;

  always_comb begin
    for (int i = 0; i < N_LFSR; i++) begin
      match[i] = (lfsr_state[i] == candidate);
    end
  end

  onehot_prio_enc u_prio_enc (
    .vec  (match),
    .idx  (match_idx),
    .none (match_none)
  );

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state   <= IDLE;
      rd_ptr  <= '0;
      tap_sel <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      rd_ptr  <= rd_ptr_nxt;
      tap_sel <= tap_sel_nxt;
      err     <= err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    rd_ptr_nxt  = rd_ptr;
    tap_sel_nxt = tap_sel;
    err_nxt     = err;
    busy        = 1'b0;
    done        = 1'b0;
    mem_raddr   = '0;
    mem_waddr   = DST;
    mem_wdata   = '0;
    mem_wr_en   = 1'b0;
    lfsr_load   = 1'b0;
    lfsr_en     = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD;
          err_nxt   = 1'b0;
        end
      end
      LOAD: begin
        busy       = 1'b1;
        mem_raddr  = SRC;
        lfsr_load  = 1'b1;
        rd_ptr_nxt = 8'd1;
        state_nxt  = PRIME;
      end
      // Re-reading byte 0 keeps the address bus quiet while the bank steps to S1.
      PRIME: begin
        busy      = 1'b1;
        mem_raddr = SRC;
        lfsr_en   = 1'b1;
        state_nxt = TRAIN;
      end
      TRAIN: begin
        busy       = 1'b1;
        mem_raddr  = SRC + rd_ptr;
        lfsr_en    = 1'b1;
        rd_ptr_nxt = rd_ptr + 8'd1;
        if (rd_ptr == LAST_TRAIN) begin
          tap_sel_nxt = match_idx;
          if (match_none) begin
            err_nxt   = 1'b1;
            state_nxt = DONE;
          end else begin
            state_nxt = STREAM;
          end
        end
      end
      STREAM: begin
        busy       = 1'b1;
        mem_raddr  = SRC + rd_ptr;
        lfsr_en    = 1'b1;
        mem_wr_en  = 1'b1;
        mem_waddr  = DST + rd_ptr - PRE;
        mem_wdata  = {mem_rdata[7:6], mem_rdata[5:0] ^ lfsr_state[tap_sel]};
        rd_ptr_nxt = rd_ptr + 8'd1;
        if (rd_ptr == LAST_BYTE) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_decrypt_seq_ctrl.sv
// Bench for decrypt_seq_ctrl: models dat_mem and the six LFSRs around the DUT and
// predicts the decrypted memory image from keystream sequences computed per tap.
module tb_decrypt_seq_ctrl;
  import decrypt_pkg::*;

  localparam int SRC_BASE = 64;
  localparam int DST_BASE = 0;
  localparam int MSG_LEN  = 64;
  localparam int PRE_LEN  = 7;
  localparam int MAX_CYC  = MSG_LEN + 8;

  logic                   clk = 1'b0;
  logic                   init_n;
  logic                   start;
  logic                   busy, done, err;
  logic [7:0]             mem_raddr, mem_rdata, mem_waddr, mem_wdata;
  logic                   mem_wr_en, lfsr_load, lfsr_en;
  logic [5:0]             lfsr_start;
  logic [N_LFSR-1:0][5:0] lfsr_state;
  logic [2:0]             tap_sel;

  logic [7:0] mem   [256];
  logic [7:0] image [256];
  logic       loadImage;
  logic [5:0] lfsrReg [N_LFSR];
  logic       forceMulti;

  logic [7:0] plain  [MSG_LEN];
  logic [7:0] cipher [MSG_LEN];
  logic [5:0] stream [N_LFSR][MSG_LEN];

  int compared;
  int mismatched;
  int writeCount   = 0;
  int overlapCount = 0;

  always #5 clk = ~clk;

  decrypt_seq_ctrl #(
    .SRC_BASE (SRC_BASE),
    .DST_BASE (DST_BASE),
    .MSG_LEN  (MSG_LEN),
    .PRE_LEN  (PRE_LEN)
  ) dut (
    .clk        (clk),
    .init_n     (init_n),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_wr_en  (mem_wr_en),
    .lfsr_load  (lfsr_load),
    .lfsr_en    (lfsr_en),
    .lfsr_start (lfsr_start),
    .lfsr_state (lfsr_state),
    .tap_sel    (tap_sel)
  );

  function automatic logic [5:0] lfsrStep(input logic [5:0] s, input logic [5:0] taps);
    return {s[4:0], ^(s & taps)};
  endfunction

  // dat_mem: asynchronous read, synchronous write, plus a one-cycle bulk preload.
  assign mem_rdata = mem[mem_raddr];

  always @(posedge clk) begin
    if (loadImage) begin
      for (int a = 0; a < 256; a++) mem[a] <= image[a];
    end else if (mem_wr_en) begin
      mem[mem_waddr] <= mem_wdata;
      writeCount     <= writeCount + 1;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N_LFSR; i++) begin
      if (lfsr_load)    lfsrReg[i] <= lfsr_start;
      else if (lfsr_en) lfsrReg[i] <= lfsrStep(lfsrReg[i], LFSR_TAPS[i]);
    end
  end

  always_comb begin
    for (int i = 0; i < N_LFSR; i++) lfsr_state[i] = lfsrReg[i];
    if (forceMulti) lfsr_state[4] = lfsrReg[1];
  end

  always @(negedge clk) begin
    if (lfsr_load && lfsr_en) overlapCount <= overlapCount + 1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput(tag, {busy, done, err, mem_raddr, mem_waddr, mem_wdata,
                      mem_wr_en, lfsr_load, lfsr_en, tap_sel}, 64'd0);
  endtask

  task automatic setPlain(input bit rnd);
    string text = "Hello world";
    for (int k = 0; k < PRE_LEN; k++) plain[k] = PREAMBLE_CHAR;
    for (int k = PRE_LEN; k < MSG_LEN; k++) begin
      int j = k - PRE_LEN;
      if (rnd)                 plain[k] = 8'($urandom);
      else if (j < text.len()) plain[k] = text[j];
      else                     plain[k] = 8'h20;
    end
  endtask

  // Keystream of each tap from the seed, then encrypt with the chosen tap.
  task automatic prepareMessage(input logic [5:0] seed, input int encTap, input bit corrupt, input bit multi);
    logic [5:0] s;
    int pick;
    for (int i = 0; i < N_LFSR; i++) begin
      s = seed;
      for (int k = 0; k < MSG_LEN; k++) begin
        stream[i][k] = s;
        s = lfsrStep(s, LFSR_TAPS[i]);
      end
    end
    if (multi) begin
      for (int k = 0; k < MSG_LEN; k++) stream[4][k] = stream[1][k];
    end
    for (int k = 0; k < MSG_LEN; k++)
      cipher[k] = {plain[k][7:6], plain[k][5:0] ^ stream[encTap][k]};
    if (corrupt) begin
      pick = 0;
      for (int v = 63; v >= 0; v--) begin
        bit used = 1'b0;
        for (int i = 0; i < N_LFSR; i++)
          if (stream[i][PRE_LEN-1] == 6'(v)) used = 1'b1;
        if (!used) pick = v;
      end
      cipher[PRE_LEN-1] = {cipher[PRE_LEN-1][7:6], 6'(pick) ^ SEED_MASK};
    end
  endtask

  task automatic loadMemory();
    for (int a = 0; a < 256; a++) image[a] = 8'($urandom);
    for (int k = 0; k < MSG_LEN; k++) image[SRC_BASE + k] = cipher[k];
    @(negedge clk) loadImage = 1'b1;
    @(negedge clk) loadImage = 1'b0;
  endtask

  task automatic applyStimulus(input int extra1, input int extra2,
                               output int doneCycle, output int doneCount, output int writes,
                               output logic busyAfter, output logic errAtDone, output logic [2:0] tapAtDone);
    doneCycle = -1;
    doneCount = 0;
    writes    = 0;
    busyAfter = 1'b1;
    errAtDone = 1'bx;
    tapAtDone = 3'bx;
    @(negedge clk) start = 1'b1;
    for (int c = 1; c <= MAX_CYC; c++) begin
      @(negedge clk);
      start = (c == extra1) || (c == extra2);
      if (mem_wr_en) writes++;
      if (done) begin
        doneCount++;
        if (doneCycle < 0) begin
          doneCycle = c;
          errAtDone = err;
          tapAtDone = tap_sel;
        end
      end
      if (doneCycle >= 0 && c == doneCycle + 1) begin
        busyAfter = busy;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic runCase(input string tag, input int encTap, input logic [5:0] seed, input bit rnd,
                         input bit corrupt, input bit multi, input int extra1, input int extra2,
                         input int fixedTap, input bit skipLoad);
    logic [7:0] expImg [256];
    logic [5:0] cand;
    int         expTap, doneCycle, doneCount, writes, diff;
    bit         expErr;
    logic       busyAfter, errAtDone;
    logic [2:0] tapAtDone;

    forceMulti = multi;
    if (!skipLoad) begin
      setPlain(rnd);
      prepareMessage(seed, encTap, corrupt, multi);
      loadMemory();
    end

    cand   = seed_of(cipher[PRE_LEN-1]);
    expTap = 0;
    expErr = 1'b1;
    for (int i = 0; i < N_LFSR; i++) begin
      if (stream[i][PRE_LEN-1] == cand) begin
        expTap = i;
        expErr = 1'b0;
      end
    end
    if (fixedTap >= 0) expTap = fixedTap;
    for (int a = 0; a < 256; a++) expImg[a] = image[a];
    if (!expErr) begin
      for (int k = PRE_LEN; k < MSG_LEN; k++)
        expImg[DST_BASE + k - PRE_LEN] = {cipher[k][7:6], cipher[k][5:0] ^ stream[expTap][k]};
    end

    applyStimulus(extra1, extra2, doneCycle, doneCount, writes, busyAfter, errAtDone, tapAtDone);

    checkOutput($sformatf("%s.doneCycle", tag), 64'(doneCycle), expErr ? 64'(PRE_LEN + 2) : 64'(MSG_LEN + 2));
    checkOutput($sformatf("%s.doneCount", tag), 64'(doneCount), 64'd1);
    checkOutput($sformatf("%s.writes", tag), 64'(writes), expErr ? 64'd0 : 64'(MSG_LEN - PRE_LEN));
    checkOutput($sformatf("%s.err", tag), 64'(errAtDone), 64'(expErr));
    if (!expErr) checkOutput($sformatf("%s.tapSel", tag), 64'(tapAtDone), 64'(expTap));
    checkOutput($sformatf("%s.busyAfterDone", tag), 64'(busyAfter), 64'd0);
    diff = 0;
    for (int a = 0; a < 256; a++) if (mem[a] !== expImg[a]) diff++;
    checkOutput($sformatf("%s.memBytesWrong", tag), 64'(diff), 64'd0);
    forceMulti = 1'b0;
  endtask

  // Interrupt a nominal run with reset in cycle 30, then rerun it from scratch.
  task automatic runResetCase();
    int wc;
    setPlain(1'b0);
    prepareMessage(6'h15, 1, 1'b0, 1'b0);
    loadMemory();
    @(negedge clk) start = 1'b1;
    for (int c = 1; c < 30; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(negedge clk);
    init_n = 1'b0;
    wc = writeCount;
    #1;
    checkQuiet("midReset.outputsAtAssert");
    @(negedge clk);
    checkQuiet("midReset.outputsHeld");
    @(negedge clk);
    checkOutput("midReset.noWriteAfterReset", 64'(writeCount - wc), 64'd0);
    init_n = 1'b1;
    runCase("afterReset", 1, 6'h15, 1'b0, 1'b0, 1'b0, -1, -1, 1, 1'b1);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    start      = 1'b0;
    loadImage  = 1'b0;
    forceMulti = 1'b0;
    init_n     = 1'b0;

    setPlain(1'b0);
    prepareMessage(6'h15, 1, 1'b0, 1'b0);
    loadMemory();
    @(negedge clk);
    checkQuiet("reset.outputs");
    checkOutput("reset.lfsrStart", 64'(lfsr_start), 64'(mem[0][5:0] ^ 6'h1F));
    init_n = 1'b1;
    @(negedge clk);

    runCase("nominal", 1, 6'h15, 1'b0, 1'b0, 1'b0, -1, -1, 1, 1'b0);
    for (int t = 0; t < N_LFSR; t++) begin
      if (t != 1) runCase($sformatf("tap%0d", t), t, 6'h15, 1'b0, 1'b0, 1'b0, -1, -1, t, 1'b0);
    end
    runCase("noMatch", 1, 6'h15, 1'b0, 1'b1, 1'b0, -1, -1, -1, 1'b0);
    runCase("multiMatch", 1, 6'h15, 1'b0, 1'b0, 1'b1, -1, -1, 4, 1'b0);
    runCase("startWhileBusy", 1, 6'h15, 1'b0, 1'b0, 1'b0, 20, 66, 1, 1'b0);
    runCase("restartFromIdle", 1, 6'h15, 1'b0, 1'b0, 1'b0, -1, -1, 1, 1'b0);
    runResetCase();

    for (int r = 0; r < 8; r++) begin
      logic [5:0] seed;
      int         tap;
      seed = 6'($urandom_range(1, 63));
      tap  = $urandom_range(0, N_LFSR - 1);
      runCase($sformatf("random%0d", r), tap, seed, 1'b1, (r % 4) == 3, 1'b0, -1, -1, -1, 1'b0);
    end

    checkOutput("loadEnOverlap", 64'(overlapCount), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/decrypt_seq_ctrl.md
# decrypt_seq_ctrl

Sequencer for the LFSR stream-decryption datapath. It owns the `dat_mem` read/write ports and the six parallel `lfsr6b` instances. On a `start` pulse it performs the following steps:
- reads the encrypted message;
- seeds the LFSRs from the first preamble byte;
- identifies the tap pattern that reproduces the preamble;
- writes the decrypted payload back to memory;
- reports `done` or an error.

It replaces hard-coded cycle-count sequencing with a handshaked, parameterized FSM.

## Interface
Parameters:
- `SRC_BASE`, 64: memory address of encrypted byte 0.
- `DST_BASE`, 0: memory address of the first decrypted payload byte.
- `MSG_LEN`, 64: total encrypted bytes, preamble included.
- `PRE_LEN`, 7: number of preamble bytes. Constraints: 2 ≤ `PRE_LEN` < `MSG_LEN`, and `SRC_BASE`+`MSG_LEN` ≤ 256.

Ports:
- `clk`  in  1  single clock, rising edge.
- `init_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request pulse, sampled only in IDLE.
- `busy`  out  1  high from LOAD through STREAM.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  no tap matched. Valid while `done`=1; holds until next accepted `start`.
- `mem_raddr`  out  8  `dat_mem` read address (asynchronous read).
- `mem_rdata`  in  8  `dat_mem` read data.
- `mem_waddr`  out  8  `dat_mem` write address.
- `mem_wdata`  out  8  `dat_mem` write data.
- `mem_wr_en`  out  1  `dat_mem` write enable.
- `lfsr_load`  out  1  load all six LFSRs from `lfsr_start`.
- `lfsr_en`  out  1  advance all six LFSRs.
- `lfsr_start`  out  6  seed, equal to `mem_rdata[5:0]` ^ 6'h1F.
- `lfsr_state`  in  6×6  current states of LFSRs 0..5 (taps 21,2D,30,33,36,39 hex).
- `tap_sel`  out  3  selected LFSR index, registered.

## Operation
- States are IDLE, LOAD, PRIME, TRAIN, STREAM, DONE.
- Internal `rd_ptr` is 8 bits wide. All address arithmetic is 8-bit unsigned.
- **IDLE:** all strobes are 0. If `start`=1, go to LOAD and clear `err`. Otherwise stay in IDLE.
- **LOAD** (1 cycle):
  - `mem_raddr`=`SRC_BASE` and `lfsr_load`=1. The LFSRs hold S0 = byte0[5:0]^1F afterwards.
  - Set `rd_ptr`=1. Go to PRIME.
- **PRIME** (1 cycle):
  - `mem_raddr`=`SRC_BASE` and `lfsr_en`=1. The LFSRs then hold S1.
  - Go to TRAIN.
- **TRAIN** (`rd_ptr` = 1..`PRE_LEN`−1):
  - `mem_raddr`=`SRC_BASE`+`rd_ptr`, `lfsr_en`=1, `rd_ptr`++.
  - In the cycle where `rd_ptr`=`PRE_LEN`−1, register `match[i]` = (`lfsr_state[i]` == `mem_rdata[5:0]`^1F) for i = 0..5.
  - Priority-encode `match` with the highest index winning; the result becomes `tap_sel`.
  - If `match`==0: set `err`=1 and go to DONE.
  - Otherwise go to STREAM.
- **STREAM** (`rd_ptr` = `PRE_LEN`..`MSG_LEN`−1):
  - `mem_raddr`=`SRC_BASE`+`rd_ptr`, `lfsr_en`=1, `mem_wr_en`=1.
  - `mem_waddr`=`DST_BASE`+`rd_ptr`−`PRE_LEN`.
  - `mem_wdata` = {`mem_rdata[7:6]`, `mem_rdata[5:0]`^`lfsr_state[tap_sel]`}.
  - After the `rd_ptr`=`MSG_LEN`−1 cycle, go to DONE.
- **DONE** (1 cycle): `done`=1, `busy`=0. `start` is ignored in this cycle. Go to IDLE.
- `start` in any state other than IDLE is ignored. There is no queueing.
- Outside STREAM, `mem_wr_en`=0 and `mem_waddr`=`DST_BASE`.
- Outside LOAD, PRIME, TRAIN and STREAM, `mem_raddr`=0.

## Timing
- Cycle numbering: cycle 0 is the IDLE cycle in which `start`=1 is sampled.
- With defaults:
  - cycle 1: LOAD
  - cycle 2: PRIME
  - cycles 3–8: TRAIN; `match` captured at the end of cycle 8
  - cycles 9–65: STREAM; writes to `waddr` 0..56
  - cycle 66: DONE
- General formula: `done` is asserted in cycle `MSG_LEN`+2.
- On error, `done` is asserted in cycle `PRE_LEN`+2, with zero writes.
- Reset values: state=IDLE, `rd_ptr`=0, `tap_sel`=0, `err`=0.
- All outputs are 0 in reset, except `lfsr_start`, which follows `mem_rdata` combinationally.
- `init_n` low mid-operation: the next cycle has no write. State returns to IDLE. A new `start` after release behaves as from power-up.
- `lfsr_load` and `lfsr_en` are never asserted in the same cycle.

## Structure
- Package `decrypt_pkg` holds:
  - the state enum `seq_state_t`;
  - `PREAMBLE_CHAR` = 8'h5F;
  - `SEED_MASK` = 6'h1F;
  - `LFSR_TAPS[6]`;
  - `N_LFSR` = 6.
- Sub-module `onehot_prio_enc`: 6-bit vector to 3-bit index, highest set bit wins, all-zero gives 0 plus a `none` flag.

## Test plan
- **Nominal decode.** Stimulus: message = 7×"_" + "Hello world" padded with spaces, encrypted with taps 2D from seed 0x15. Response: `tap_sel`=1, `err`=0, `done` in cycle 66, memory[0..56] equals the plaintext, memory[57..63] unchanged.
- **Each tap.** Stimulus: repeat the nominal test for taps 21, 30, 33, 36, 39. Response: `tap_sel` = 0, 2, 3, 4, 5 respectively, and the plaintext is correct.
- **No match.** Stimulus: corrupt byte 6 of the preamble. Response: `err`=1, `done` in cycle 9, `mem_wr_en` never asserted.
- **Multiple match.** Stimulus: force `lfsr_state[1]` and `lfsr_state[4]` both equal to the cycle-8 candidate. Response: `tap_sel`=4.
- **Start during busy.** Stimulus: pulse `start` in cycles 20 and 66. Response: no restart, exactly one `done`, and a new run accepted only from IDLE (cycle ≥67).
- **Reset mid-run.** Stimulus: drive `init_n`=0 in cycle 30 for 2 cycles, then `start`. Response: all outputs 0 during reset, no write after the reset edge, and the full nominal result on the rerun.
